// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter that shares a single tinyalu between N_REQ requesters.
// Drives the tinyalu start/done handshake and returns each result tagged with its requester id.
module tinyalu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_A,
  input  logic [8*N_REQ-1:0]   req_B,
  input  logic [3*N_REQ-1:0]   req_op,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_LOCAL = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic [ID_W:0]   scan_idx;
  logic            accept;

  logic [7:0]      a_arr  [N_REQ];
  logic [7:0]      b_arr  [N_REQ];
  logic [2:0]      op_arr [N_REQ];
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic [2:0]      sel_op;

  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic [2:0]      op_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      cnt;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      a_arr[k]  = req_A[8*k +: 8];
      b_arr[k]  = req_B[8*k +: 8];
      op_arr[k] = req_op[3*k +: 3];
    end
  end

  // Scan from the highest offset down so the nearest valid requester after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(N_REQ))
        scan_idx = scan_idx - (ID_W+1)'(N_REQ);
      if (req_valid[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  assign accept = (state == S_IDLE) && grant_found;
  assign sel_a  = a_arr[grant_idx];
  assign sel_b  = b_arr[grant_idx];
  assign sel_op = op_arr[grant_idx];

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[grant_idx] = 1'b1;
  end

  // Combinational from state so alu_start drops the moment reset clears state.
  assign alu_start = (state == S_BUSY);
  assign alu_A     = alu_start ? a_q  : 8'd0;
  assign alu_B     = alu_start ? b_q  : 8'd0;
  assign alu_op    = alu_start ? op_q : 3'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            op_q <= sel_op;
            id_q <= grant_idx;
            cnt  <= '0;
            if (sel_op >= 3'b001 && sel_op <= 3'b100)
              state <= S_BUSY;
            else
              state <= S_LOCAL;
          end
        end
        S_BUSY: begin
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_LOCAL: begin
          rsp_result <= '0;
          rsp_err    <= (op_q >= 3'b101);
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        default: begin
          rsp_valid <= 1'b0;
          rr_ptr    <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter with a fixed-latency tinyalu stand-in.
// Expected values are hand-computed constants checked with immediate assertions.
module tb_tinyalu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_A;
  logic [31:0] req_B;
  logic [11:0] req_op;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done   = 1'b0;
  logic [15:0] alu_result = 16'd0;

  logic        done_en     = 1'b1;
  int          busy_cnt    = 0;
  int          start_cycles = 0;
  int          start_rises  = 0;
  int          rsp_seen     = 0;
  logic        prev_start   = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;

  tinyalu_arbiter #(.N_REQ(4), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  // tinyalu stand-in: done pulses on the third cycle of start, unless disabled.
  always @(negedge clk) begin
    if (alu_start && done_en) begin
      busy_cnt <= busy_cnt + 1;
      if (busy_cnt == 2) begin
        alu_done <= 1'b1;
        case (alu_op)
          3'b001:  alu_result <= 16'(alu_A) + 16'(alu_B);
          3'b010:  alu_result <= 16'(alu_A & alu_B);
          3'b011:  alu_result <= 16'(alu_A ^ alu_B);
          3'b100:  alu_result <= 16'(alu_A) * 16'(alu_B);
          default: alu_result <= 16'hDEAD;
        endcase
      end else begin
        alu_done <= 1'b0;
      end
    end else begin
      busy_cnt <= 0;
      alu_done <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (alu_start) start_cycles <= start_cycles + 1;
    if (alu_start && !prev_start) start_rises <= start_rises + 1;
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
    prev_start <= alu_start;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] op);
    req_A[8*idx +: 8]  = a;
    req_B[8*idx +: 8]  = b;
    req_op[3*idx +: 3] = op;
  endtask

  task automatic wait_rsp(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  int exp_ids [5] = '{0, 1, 2, 3, 0};

  initial begin
    bit ok;
    int s0;
    int r0;
    int v0;

    reset = 1'b1; req_valid = '0; req_A = '0; req_B = '0; req_op = '0;
    tick(); tick();
    check_output("reset_req_ready", 32'(req_ready), 0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 0);
    check_output("reset_alu_start", 32'(alu_start), 0);
    check_output("reset_rsp_result", 32'(rsp_result), 0);
    check_output("reset_alu_A", 32'(alu_A), 0);
    reset = 1'b0;
    tick();
    check_output("idle_rsp_id", 32'(rsp_id), 0);
    check_output("idle_alu_op", 32'(alu_op), 0);

    $display("[TB] add FF+01 on requester 0");
    apply_stimulus(0, 8'hFF, 8'h01, 3'b001);
    req_valid = 4'b0001;
    #1;
    check_output("add_ready", 32'(req_ready), 'h1);
    tick();
    req_valid = '0;
    s0 = start_cycles;
    check_output("add_start", 32'(alu_start), 1);
    check_output("add_alu_A", 32'(alu_A), 'hFF);
    check_output("add_alu_B", 32'(alu_B), 'h01);
    check_output("add_alu_op", 32'(alu_op), 1);
    check_output("add_ready_busy", 32'(req_ready), 0);
    wait_rsp(40, ok);
    check_output("add_rsp_seen", 32'(ok), 1);
    check_output("add_rsp_id", 32'(rsp_id), 0);
    check_output("add_rsp_result", 32'(rsp_result), 'h100);
    check_output("add_rsp_err", 32'(rsp_err), 0);
    check_output("add_start_cycles", 32'(start_cycles - s0), 3);
    tick();
    check_output("add_rsp_pulse", 32'(rsp_valid), 0);
    check_output("add_rsp_hold", 32'(rsp_result), 'h100);

    $display("[TB] round robin mul on all requesters");
    reset = 1'b1; tick(); reset = 1'b0; tick();
    for (int i = 0; i < 4; i++) apply_stimulus(i, 8'd200, 8'd100, 3'b100);
    req_valid = 4'hF;
    #1;
    check_output("rr_first_ready", 32'(req_ready), 'h1);
    r0 = start_rises;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(40, ok);
      check_output("rr_rsp_seen", 32'(ok), 1);
      check_output("rr_rsp_id", 32'(rsp_id), 32'(exp_ids[k]));
      check_output("rr_rsp_result", 32'(rsp_result), 20000);
      check_output("rr_rsp_err", 32'(rsp_err), 0);
      if (k == 4) req_valid = '0;
      tick();
    end
    check_output("rr_start_rises", 32'(start_rises - r0), 5);

    $display("[TB] illegal opcode on requester 2");
    apply_stimulus(2, 8'h12, 8'h34, 3'b110);
    req_valid = 4'b0100;
    #1;
    check_output("ill_ready", 32'(req_ready), 'h4);
    s0 = start_cycles;
    tick();
    req_valid = '0;
    check_output("ill_no_start", 32'(alu_start), 0);
    wait_rsp(40, ok);
    check_output("ill_rsp_seen", 32'(ok), 1);
    check_output("ill_rsp_id", 32'(rsp_id), 2);
    check_output("ill_rsp_err", 32'(rsp_err), 1);
    check_output("ill_rsp_result", 32'(rsp_result), 0);
    check_output("ill_start_cycles", 32'(start_cycles - s0), 0);
    tick();

    $display("[TB] no_op on requester 1");
    apply_stimulus(1, 8'h55, 8'hAA, 3'b000);
    req_valid = 4'b0010;
    #1;
    check_output("nop_ready", 32'(req_ready), 'h2);
    s0 = start_cycles;
    tick();
    req_valid = '0;
    check_output("nop_local_no_rsp", 32'(rsp_valid), 0);
    check_output("nop_no_start", 32'(alu_start), 0);
    tick();
    check_output("nop_rsp_valid", 32'(rsp_valid), 1);
    check_output("nop_rsp_id", 32'(rsp_id), 1);
    check_output("nop_rsp_err", 32'(rsp_err), 0);
    check_output("nop_rsp_result", 32'(rsp_result), 0);
    check_output("nop_start_cycles", 32'(start_cycles - s0), 0);
    tick();

    $display("[TB] xor on requester 3 with alu_done held low");
    done_en = 1'b0;
    apply_stimulus(3, 8'hF0, 8'h0F, 3'b011);
    req_valid = 4'b1000;
    #1;
    check_output("to_ready", 32'(req_ready), 'h8);
    tick();
    req_valid = '0;
    s0 = start_cycles;
    wait_rsp(40, ok);
    check_output("to_rsp_seen", 32'(ok), 1);
    check_output("to_rsp_id", 32'(rsp_id), 3);
    check_output("to_rsp_err", 32'(rsp_err), 1);
    check_output("to_rsp_result", 32'(rsp_result), 0);
    check_output("to_start_cycles", 32'(start_cycles - s0), 15);
    tick();
    done_en = 1'b1;
    apply_stimulus(0, 8'd3, 8'd4, 3'b001);
    req_valid = 4'b0001;
    #1;
    check_output("post_to_ready", 32'(req_ready), 'h1);
    tick();
    req_valid = '0;
    wait_rsp(40, ok);
    check_output("post_to_rsp_seen", 32'(ok), 1);
    check_output("post_to_rsp_id", 32'(rsp_id), 0);
    check_output("post_to_rsp_result", 32'(rsp_result), 7);
    check_output("post_to_rsp_err", 32'(rsp_err), 0);
    tick();

    $display("[TB] reset asserted during a mul");
    apply_stimulus(2, 8'd200, 8'd100, 3'b100);
    req_valid = 4'b0100;
    #1;
    check_output("mid_ready", 32'(req_ready), 'h4);
    tick();
    req_valid = '0;
    check_output("mid_start_before", 32'(alu_start), 1);
    v0 = rsp_seen;
    #2 reset = 1'b1;
    #1;
    check_output("mid_start_async", 32'(alu_start), 0);
    check_output("mid_alu_A", 32'(alu_A), 0);
    tick(); tick();
    reset = 1'b0;
    repeat (8) tick();
    check_output("mid_no_rsp", 32'(rsp_seen - v0), 0);
    check_output("mid_start_idle", 32'(alu_start), 0);
    apply_stimulus(0, 8'd1, 8'd2, 3'b001);
    req_valid = 4'b0101;
    #1;
    check_output("mid_ptr_reset_ready", 32'(req_ready), 'h1);
    tick();
    req_valid = '0;
    wait_rsp(40, ok);
    check_output("mid_rsp_seen", 32'(ok), 1);
    check_output("mid_rsp_id", 32'(rsp_id), 0);
    check_output("mid_rsp_result", 32'(rsp_result), 3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
